gray_fifo_ctrl: RTL

//  Single-clock FIFO pointer controller built on two Gray-coded counters (write and read).

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_ptr.sv | 49 ++++
 rtl/gray_fifo_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
//------------------------------------------------------------------------------
// Module   : gray_pkg
// Brief    : Shared Gray-code helpers and default pointer widths for the FIFO
//            controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package gray_pkg;

    localparam int c_ADDR_W_DEF = 3;
    localparam int PTR_W        = c_ADDR_W_DEF + 1;
    localparam int c_MAX_W      = 32;

    function automatic logic [c_MAX_W-1:0] bin2gray(input logic [c_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [c_MAX_W-1:0] gray2bin(input logic [c_MAX_W-1:0] g);
        logic [c_MAX_W-1:0] b;
        b[c_MAX_W-1] = g[c_MAX_W-1];
        for (int i = c_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_ptr.sv
//------------------------------------------------------------------------------
// Module   : gray_ptr
// Brief    : Binary counter with a registered Gray twin; exposes both current
//            and next values so the parent can derive flags one cycle ahead.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_ptr
    import gray_pkg::*;
#(
    parameter int W = PTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray_next
);

    logic [W-1:0]       r_bin;
    logic [W-1:0]       r_gray;
    logic [c_MAX_W-1:0] w_gray_wide;
    logic               w_unused_gray;

    // Natural modulo-2**W wrap keeps the Gray step to a single bit at rollover.
    assign bin_next      = r_bin + {{(W-1){1'b0}}, inc};
    assign w_gray_wide   = bin2gray(c_MAX_W'(bin_next));
    assign gray_next     = w_gray_wide[W-1:0];
    assign w_unused_gray = ^w_gray_wide[c_MAX_W-1:W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= bin_next;
            r_gray <= gray_next;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;

endmodule

`default_nettype wire

// File: rtl/gray_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module   : gray_fifo_ctrl
// Brief    : Single-clock FIFO pointer controller using Gray-coded write/read
//            pointers; drives RAM strobes/addresses and full/empty/count flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gray_fifo_ctrl
    import gray_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   wr_gptr,
    output logic [ADDR_W:0]   rd_gptr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int c_PTR_W = ADDR_W + 1;

    logic [c_PTR_W-1:0] w_wr_bin, w_wr_gray, w_wr_bin_n, w_wr_gray_n;
    logic [c_PTR_W-1:0] w_rd_bin, w_rd_gray, w_rd_bin_n, w_rd_gray_n;
    logic [c_PTR_W-1:0] w_rd_gray_n_flip;
    logic               w_wr_en, w_rd_en;

    logic               r_full, r_empty, r_ovf, r_udf;
    logic [c_PTR_W-1:0] r_count;

    // Acceptance looks only at registered flags; no same-cycle bypass.
    assign w_wr_en = wr_req & ~r_full;
    assign w_rd_en = rd_req & ~r_empty;

    gray_ptr #(.W(c_PTR_W)) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_wr_en),
        .bin       (w_wr_bin),
        .gray      (w_wr_gray),
        .bin_next  (w_wr_bin_n),
        .gray_next (w_wr_gray_n)
    );

    gray_ptr #(.W(c_PTR_W)) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_rd_en),
        .bin       (w_rd_bin),
        .gray      (w_rd_gray),
        .bin_next  (w_rd_bin_n),
        .gray_next (w_rd_gray_n)
    );

    // In Gray space, "one full lap ahead" means the top two bits are inverted.
    assign w_rd_gray_n_flip = {~w_rd_gray_n[ADDR_W:ADDR_W-1], w_rd_gray_n[ADDR_W-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_full  <= (w_wr_gray_n == w_rd_gray_n_flip);
            r_empty <= (w_wr_gray_n == w_rd_gray_n);
            r_count <= w_wr_bin_n - w_rd_bin_n;
            r_ovf   <= wr_req & r_full;
            r_udf   <= rd_req & r_empty;
        end
    end

    assign wr_en   = w_wr_en;
    assign rd_en   = w_rd_en;
    assign wr_addr = w_wr_bin[ADDR_W-1:0];
    assign rd_addr = w_rd_bin[ADDR_W-1:0];
    assign wr_gptr = w_wr_gray;
    assign rd_gptr = w_rd_gray;
    assign full    = r_full;
    assign empty   = r_empty;
    assign count   = r_count;
    assign ovf     = r_ovf;
    assign udf     = r_udf;

endmodule

`default_nettype wire
